// File: rtl/vlsu_pkg.sv
// Shared types and sizes for the vector LSU stages.
//   VLSU_LANES   : number of vector lanes
//   VLSU_DATA_W  : lane data / address width
//   vseq_state_e : lane sequencer state encoding
package vlsu_pkg;
    localparam int unsigned VLSU_LANES  = 8;
    localparam int unsigned VLSU_DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } vseq_state_e;
endpackage

// File: rtl/vlsu_lane_pick.sv
// Priority encoder: lowest set lane of a mask plus an any-set flag.
//   i_mask : lane mask
//   o_idx  : index of lowest set bit (0 when none set)
//   o_any  : at least one bit set
module vlsu_lane_pick #(
    parameter  int unsigned LANES = 8,
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top so the lowest set lane is the last one written.
    always_comb begin
        o_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        o_any = |i_mask;
    end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Serialises one vector memory operation into single-lane accesses on a
// DATA_W-bit memory port, one access outstanding at a time.
//   clk, rst           : clock, synchronous active-high reset
//   req_*              : vector operation in (valid/ready, store flag, mask, addrs, wdata)
//   mem_req_* / mem_*  : single-lane memory request (valid/ready, we, addr, wdata)
//   mem_rsp_*          : memory response / write acknowledge
//   result_*           : completion handshake, latched store flag, assembled load data
module vector_lane_sequencer
    import vlsu_pkg::*;
#(
    parameter int unsigned LANES  = VLSU_LANES,
    parameter int unsigned DATA_W = VLSU_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    is_store_i,
    input  logic [LANES-1:0]        lane_mask_i,
    input  logic [LANES*DATA_W-1:0] req_addr_i,
    input  logic [LANES*DATA_W-1:0] req_wdata_i,
    output logic                    mem_req_valid_o,
    input  logic                    mem_req_ready_i,
    output logic                    mem_we_o,
    output logic [DATA_W-1:0]       mem_addr_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    input  logic                    mem_rsp_valid_i,
    input  logic [DATA_W-1:0]       mem_rsp_data_i,
    output logic                    result_valid_o,
    input  logic                    result_ready_i,
    output logic                    result_is_store_o,
    output logic [LANES*DATA_W-1:0] load_data_o
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    vseq_state_e             r_state;
    logic                    r_is_store;
    logic [LANES-1:0]        r_pend;
    logic [IDX_W-1:0]        r_lane;
    logic [LANES*DATA_W-1:0] r_addr;
    logic [LANES*DATA_W-1:0] r_wdata;

    logic [LANES-1:0]        w_clr_mask;
    logic [LANES-1:0]        w_pick_mask;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_any;
    logic [LANES*DATA_W-1:0] w_src_addr;
    logic [LANES*DATA_W-1:0] w_src_wdata;
    logic [DATA_W-1:0]       w_next_addr;
    logic [DATA_W-1:0]       w_next_wdata;

    // The next lane is picked one cycle early so the memory outputs can be
    // registered: from the incoming mask at acceptance, otherwise from the
    // pending mask with the current lane already retired.
    assign w_clr_mask  = r_pend & ~(LANES'(1) << r_lane);
    assign w_pick_mask = (r_state == IDLE) ? lane_mask_i : w_clr_mask;
    assign w_src_addr  = (r_state == IDLE) ? req_addr_i  : r_addr;
    assign w_src_wdata = (r_state == IDLE) ? req_wdata_i : r_wdata;

    vlsu_lane_pick #(.LANES(LANES)) u_pick (
        .i_mask (w_pick_mask),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    assign w_next_addr  = w_src_addr[w_pick_idx*DATA_W +: DATA_W];
    assign w_next_wdata = w_src_wdata[w_pick_idx*DATA_W +: DATA_W];

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_is_store        <= 1'b0;
            r_pend            <= '0;
            r_lane            <= '0;
            r_addr            <= '0;
            r_wdata           <= '0;
            req_ready_o       <= 1'b1;
            mem_req_valid_o   <= 1'b0;
            mem_we_o          <= 1'b0;
            mem_addr_o        <= '0;
            mem_wdata_o       <= '0;
            result_valid_o    <= 1'b0;
            result_is_store_o <= 1'b0;
            load_data_o       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_is_store        <= is_store_i;
                        result_is_store_o <= is_store_i;
                        r_pend            <= lane_mask_i;
                        r_addr            <= req_addr_i;
                        r_wdata           <= req_wdata_i;
                        load_data_o       <= '0;
                        req_ready_o       <= 1'b0;
                        if (w_pick_any) begin
                            r_lane          <= w_pick_idx;
                            mem_req_valid_o <= 1'b1;
                            mem_we_o        <= is_store_i;
                            mem_addr_o      <= w_next_addr;
                            mem_wdata_o     <= w_next_wdata;
                            r_state         <= ISSUE;
                        end else begin
                            result_valid_o  <= 1'b1;
                            r_state         <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        r_state         <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid_i) begin
                        if (!r_is_store) begin
                            load_data_o[r_lane*DATA_W +: DATA_W] <= mem_rsp_data_i;
                        end
                        r_pend <= w_clr_mask;
                        if (w_pick_any) begin
                            r_lane          <= w_pick_idx;
                            mem_req_valid_o <= 1'b1;
                            mem_we_o        <= r_is_store;
                            mem_addr_o      <= w_next_addr;
                            mem_wdata_o     <= w_next_wdata;
                            r_state         <= ISSUE;
                        end else begin
                            result_valid_o  <= 1'b1;
                            r_state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        req_ready_o    <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer with a responding memory model
// and queues of expected accesses and results.
module tb_vector_lane_sequencer;

    typedef struct packed {
        logic        stalled;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } acc_t;

    typedef struct packed {
        logic         is_store;
        logic [511:0] data;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid_i;
    logic         req_ready_o;
    logic         is_store_i;
    logic [7:0]   lane_mask_i;
    logic [511:0] req_addr_i;
    logic [511:0] req_wdata_i;
    logic         mem_req_valid_o;
    logic         mem_req_ready_i = 1'b0;
    logic         mem_we_o;
    logic [63:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o;
    logic         mem_rsp_valid_i = 1'b0;
    logic [63:0]  mem_rsp_data_i = '0;
    logic         result_valid_o;
    logic         result_ready_i;
    logic         result_is_store_o;
    logic [511:0] load_data_o;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int t0      = 0;

    acc_t exp_acc[$];
    acc_t obs_acc[$];
    res_t exp_res[$];

    // Memory model knobs (written by the stimulus only).
    logic [63:0] stall_addr = '1;
    int          stall_n    = 0;
    int          stall_gen  = 0;
    logic [63:0] dly_addr   = '1;
    int          dly_n      = 0;
    int          stray_req  = 0;

    // Memory model state (written by the responder only).
    int          seen_gen   = 0;
    int          stall_cnt  = 0;
    int          stray_done = 0;
    int          hs_count   = 0;
    logic        rsp_busy   = 1'b0;
    int          rsp_wait   = 0;
    logic [63:0] rsp_data   = '0;

    vector_lane_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .is_store_i        (is_store_i),
        .lane_mask_i       (lane_mask_i),
        .req_addr_i        (req_addr_i),
        .req_wdata_i       (req_wdata_i),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_rsp_valid_i   (mem_rsp_valid_i),
        .mem_rsp_data_i    (mem_rsp_data_i),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready_i),
        .result_is_store_o (result_is_store_o),
        .load_data_o       (load_data_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        return 64'hA0 + ((a - 64'h1000) >> 3);
    endfunction

    // Memory responder: decides ready for the coming edge, returns each
    // response after a configurable delay, and logs every observed request.
    always @(negedge clk) begin
        mem_req_ready_i <= 1'b0;
        mem_rsp_valid_i <= 1'b0;
        if (stall_gen != seen_gen) begin
            seen_gen  <= stall_gen;
            stall_cnt <= 0;
        end
        if (rsp_busy) begin
            if (rsp_wait == 0) begin
                mem_rsp_valid_i <= 1'b1;
                mem_rsp_data_i  <= rsp_data;
                rsp_busy        <= 1'b0;
            end else begin
                rsp_wait <= rsp_wait - 1;
            end
        end else if (stray_req != stray_done) begin
            mem_rsp_valid_i <= 1'b1;
            mem_rsp_data_i  <= 64'hDEAD_BEEF_0BAD_F00D;
            stray_done      <= stray_req;
        end
        if (mem_req_valid_o && !rst) begin
            if (mem_addr_o == stall_addr && stall_gen == seen_gen && stall_cnt < stall_n) begin
                stall_cnt <= stall_cnt + 1;
                obs_acc.push_back('{1'b1, mem_we_o, mem_addr_o, mem_wdata_o});
            end else begin
                mem_req_ready_i <= 1'b1;
                obs_acc.push_back('{1'b0, mem_we_o, mem_addr_o, mem_wdata_o});
                hs_count <= hs_count + 1;
                rsp_busy <= 1'b1;
                rsp_wait <= (mem_addr_o == dly_addr) ? dly_n : 0;
                rsp_data <= mem_data(mem_addr_o);
            end
        end
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_req_ready",    512'(req_ready_o),       512'(1));
        check("rst_mem_valid",    512'(mem_req_valid_o),   512'(0));
        check("rst_mem_we",       512'(mem_we_o),          512'(0));
        check("rst_result_valid", 512'(result_valid_o),    512'(0));
        check("rst_mem_addr",     512'(mem_addr_o),        512'(0));
        check("rst_mem_wdata",    512'(mem_wdata_o),       512'(0));
        check("rst_load_data",    load_data_o,             512'(0));
        check("rst_is_store",     512'(result_is_store_o), 512'(0));
    endtask

    // Compare every logged request with the expected lane order; a stalled
    // cycle must already show the access that is eventually accepted.
    task automatic drain_acc();
        acc_t o;
        acc_t e;
        while (obs_acc.size() > 0) begin
            o = obs_acc.pop_front();
            if (exp_acc.size() == 0) begin
                check("acc_extra", 512'(o.addr), 512'(64'hFFFF_FFFF_FFFF_FFFF));
            end else begin
                if (o.stalled) e = exp_acc[0];
                else           e = exp_acc.pop_front();
                check(o.stalled ? "stall_addr"  : "acc_addr",  512'(o.addr),  512'(e.addr));
                check(o.stalled ? "stall_wdata" : "acc_wdata", 512'(o.wdata), 512'(e.wdata));
                check(o.stalled ? "stall_we"    : "acc_we",    512'(o.we),    512'(e.we));
            end
        end
    endtask

    task automatic start_op(input logic st, input logic [7:0] m,
                            input logic [511:0] a, input logic [511:0] w);
        logic [511:0] exp_l;
        @(negedge clk);
        is_store_i  = st;
        lane_mask_i = m;
        req_addr_i  = a;
        req_wdata_i = w;
        req_valid_i = 1'b1;
        exp_l = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                exp_acc.push_back('{1'b0, st, a[i*64 +: 64], w[i*64 +: 64]});
                if (!st) exp_l[i*64 +: 64] = mem_data(a[i*64 +: 64]);
            end
        end
        exp_res.push_back('{st, exp_l});
        check("req_ready_idle", 512'(req_ready_o), 512'(1));
        t0 = cyc;
        @(negedge clk);
        // Scramble the request inputs: only the accepted values may matter.
        req_valid_i = 1'b0;
        is_store_i  = ~st;
        lane_mask_i = ~m;
        req_addr_i  = {8{64'h5555_5555_5555_5555}};
        req_wdata_i = ~w;
        check("req_ready_busy", 512'(req_ready_o), 512'(0));
    endtask

    task automatic finish_op(input int exp_lat, input int hold);
        int   n;
        res_t r;
        n = 0;
        while (!result_valid_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("result_timeout", 512'(result_valid_o), 512'(1));
        check("latency", 512'(cyc - t0), 512'(exp_lat));
        r = exp_res.pop_front();
        check("load_data", load_data_o, r.data);
        check("is_store", 512'(result_is_store_o), 512'(r.is_store));
        drain_acc();
        check("acc_missing", 512'(exp_acc.size()), 512'(0));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 512'(result_valid_o), 512'(1));
            check("hold_data", load_data_o, r.data);
            check("hold_req_ready", 512'(req_ready_o), 512'(0));
        end
        result_ready_i = 1'b1;
        @(negedge clk);
        result_ready_i = 1'b0;
        check("post_result_valid", 512'(result_valid_o), 512'(0));
        check("post_req_ready", 512'(req_ready_o), 512'(1));
    endtask

    initial begin : stim
        logic [511:0] a;
        logic [511:0] w;
        int           hs0;
        int           n;

        rst            = 1'b1;
        req_valid_i    = 1'b0;
        is_store_i     = 1'b0;
        lane_mask_i    = '0;
        req_addr_i     = '0;
        req_wdata_i    = '0;
        result_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values();

        // All-lane load, zero-wait memory.
        for (int i = 0; i < 8; i++) begin
            a[i*64 +: 64] = 64'h1000 + 64'(8 * i);
            w[i*64 +: 64] = 64'hCAFE_0000 + 64'(i);
        end
        start_op(1'b0, 8'hFF, a, w);
        finish_op(17, 0);

        // Sparse store on lanes 0 and 7.
        for (int i = 0; i < 8; i++) begin
            a[i*64 +: 64] = 64'h2000 + 64'(8 * i);
            w[i*64 +: 64] = 64'hEE;
        end
        w[0 +: 64]   = 64'h11;
        w[448 +: 64] = 64'h77;
        start_op(1'b1, 8'h81, a, w);
        finish_op(5, 0);

        // Empty mask: no memory traffic at all.
        hs0 = hs_count;
        start_op(1'b0, 8'h00, a, w);
        finish_op(1, 0);
        check("empty_no_access", 512'(hs_count - hs0), 512'(0));

        // Backpressure on lane 2 plus a delayed response, then held result.
        for (int i = 0; i < 8; i++) begin
            a[i*64 +: 64] = 64'h1000 + 64'(8 * i);
        end
        stall_addr = 64'h1010;
        stall_n    = 3;
        stall_gen  = stall_gen + 1;
        dly_addr   = 64'h1010;
        dly_n      = 2;
        start_op(1'b0, 8'hFF, a, w);
        finish_op(22, 4);
        stall_n = 0;
        dly_n   = 0;

        // Stray response while idle must be ignored.
        stray_req = stray_req + 1;
        repeat (3) @(negedge clk);
        check("stray_idle_ready", 512'(req_ready_o), 512'(1));
        start_op(1'b0, 8'h0F, a, w);
        finish_op(9, 0);

        // Reset during WAIT_RSP of lane 3; its response lands after reset.
        dly_addr = 64'h1018;
        dly_n    = 2;
        hs0 = hs_count;
        start_op(1'b0, 8'hFF, a, w);
        n = 0;
        while (hs_count < hs0 + 4 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("reset_reach_lane3", 512'(hs_count - hs0), 512'(4));
        @(negedge clk);
        check("wait_rsp_no_valid", 512'(mem_req_valid_o), 512'(0));
        check("wait_rsp_addr", 512'(mem_addr_o), 512'(64'h1018));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values();
        drain_acc();
        exp_acc.delete();
        exp_res.delete();
        dly_n = 0;

        // Next operation must not see the abandoned lane-3 response.
        for (int i = 0; i < 8; i++) begin
            a[i*64 +: 64] = 64'h1100 + 64'(8 * i);
        end
        start_op(1'b0, 8'h3C, a, w);
        finish_op(9, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
